// File: rtl/dht11_responder_if.sv
// Line-side and payload signals of the DHT11 responder.
// The master is the host or bench; the slave is the responder.
interface dht11_responder_if;
   logic        dht_in;
   logic        dht_drive_low;
   logic [7:0]  hum_int;
   logic [7:0]  hum_float;
   logic [7:0]  temp_int;
   logic [7:0]  temp_float;
   logic        bad_checksum;
   logic        busy;
   logic        done;
   logic [15:0] frame_count;

   modport master (
      output dht_in, hum_int, hum_float, temp_int, temp_float, bad_checksum,
      input  dht_drive_low, busy, done, frame_count
   );

   modport slave (
      input  dht_in, hum_int, hum_float, temp_int, temp_float, bad_checksum,
      output dht_drive_low, busy, done, frame_count
   );
endinterface

// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: accepts a host start pulse, answers with presence,
// then shifts out a 40-bit humidity/temperature/checksum frame open-drain.
module dht11_responder #(
   parameter int CYCLES_PER_US = 50,
   parameter int MIN_START_US  = 10000,
   parameter int RESP_DELAY_US = 30
) (
   input  logic               clk,
   input  logic               rst,
   dht11_responder_if.slave   dht_if
);

   typedef enum logic [2:0] {
      IDLE, START_LOW, WAIT_HOST, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW
   } state_t;

   localparam int PW = (CYCLES_PER_US > 1) ? $clog2(CYCLES_PER_US) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(CYCLES_PER_US - 1);
   // START_LOW is entered one cycle after the low was seen, so its
   // prescaler starts one step ahead to measure the host pulse exactly.
   localparam logic [PW-1:0] PRESC_START = (CYCLES_PER_US > 1) ? PW'(1) : '0;

   state_t        state_q, state_d;
   logic [1:0]    sync_q;
   logic [PW-1:0] presc_q, presc_d;
   logic [15:0]   us_q, us_d;
   logic [5:0]    idx_q, idx_d;
   logic [39:0]   frame_q, frame_d;
   logic          drive_q, drive_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [15:0]   fc_q, fc_d;

   logic          s_in;
   logic          tick;
   logic          phase_end;
   logic [15:0]   dur_us;
   logic [7:0]    cks;

   assign s_in = sync_q[1];
   assign tick = (presc_q == PRESC_MAX);
   assign cks  = (dht_if.hum_int + dht_if.hum_float + dht_if.temp_int + dht_if.temp_float)
                 ^ {7'd0, dht_if.bad_checksum};

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      frame_d   = frame_q;
      done_d    = 1'b0;
      fc_d      = fc_q;
      dur_us    = 16'd0;
      phase_end = 1'b0;

      unique case (state_q)
         WAIT_HOST:          dur_us = 16'(RESP_DELAY_US);
         RESP_LOW,RESP_HIGH: dur_us = 16'd80;
         BIT_LOW, END_LOW:   dur_us = 16'd50;
         BIT_HIGH:           dur_us = frame_q[39] ? 16'd70 : 16'd26;
         default:            dur_us = 16'd0;
      endcase
      phase_end = tick && (us_q == dur_us - 16'd1);

      unique case (state_q)
         IDLE: if (!s_in) state_d = START_LOW;
         START_LOW: begin
            if (s_in) begin
               if (us_q >= 16'(MIN_START_US)) begin
                  frame_d = {dht_if.hum_int, dht_if.hum_float,
                             dht_if.temp_int, dht_if.temp_float, cks};
                  state_d = WAIT_HOST;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         WAIT_HOST: if (phase_end) state_d = RESP_LOW;
         RESP_LOW:  if (phase_end) state_d = RESP_HIGH;
         RESP_HIGH: begin
            if (phase_end) begin
               idx_d   = 6'd0;
               state_d = BIT_LOW;
            end
         end
         BIT_LOW:   if (phase_end) state_d = BIT_HIGH;
         BIT_HIGH: begin
            if (phase_end) begin
               if (idx_q < 6'd39) begin
                  idx_d   = idx_q + 6'd1;
                  frame_d = {frame_q[38:0], 1'b0};
                  state_d = BIT_LOW;
               end else begin
                  state_d = END_LOW;
               end
            end
         end
         END_LOW: begin
            if (phase_end) begin
               done_d  = 1'b1;
               fc_d    = fc_q + 16'd1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_d != state_q) begin
         presc_d = (state_d == START_LOW) ? PRESC_START : '0;
         us_d    = 16'd0;
      end else begin
         presc_d = tick ? '0 : presc_q + PW'(1);
         us_d    = (tick && us_q != 16'hFFFF) ? us_q + 16'd1 : us_q;
      end

      drive_d = (state_d == RESP_LOW) || (state_d == BIT_LOW) || (state_d == END_LOW);
      busy_d  = (state_d != IDLE) && (state_d != START_LOW);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sync_q  <= 2'b11;
         presc_q <= '0;
         us_q    <= 16'd0;
         idx_q   <= 6'd0;
         frame_q <= 40'd0;
         drive_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         fc_q    <= 16'd0;
      end else begin
         state_q <= state_d;
         sync_q  <= {sync_q[0], dht_if.dht_in};
         presc_q <= presc_d;
         us_q    <= us_d;
         idx_q   <= idx_d;
         frame_q <= frame_d;
         drive_q <= drive_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         fc_q    <= fc_d;
      end
   end

   assign dht_if.dht_drive_low = drive_q;
   assign dht_if.busy          = busy_q;
   assign dht_if.done          = done_q;
   assign dht_if.frame_count   = fc_q;

endmodule

// File: tb/tb_dht11_responder.sv
// Bench for dht11_responder: plays the DHT11 host, decodes the reply by pulse
// widths and compares against a byte-level model of the frame.
module tb_dht11_responder;
   localparam int CPU = 2;
   localparam int MIN = 100;
   localparam int RD  = 30;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dht11_responder_if dif();

   dht11_responder #(.CYCLES_PER_US(CPU), .MIN_START_US(MIN), .RESP_DELAY_US(RD)) dut (
      .clk    (clk),
      .rst    (rst),
      .dht_if (dif)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   int exp_fc = 0;

   int   done_cnt  = 0;
   int   done_bad  = 0;
   logic busy_prev = 1'b0;
   always @(negedge clk) begin
      if (dif.done === 1'b1) begin
         done_cnt <= done_cnt + 1;
         if (dif.busy !== 1'b0 || busy_prev !== 1'b1) done_bad <= done_bad + 1;
      end
      busy_prev <= dif.busy;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [39:0] model(input logic [7:0] hi, hf, ti, tf, input logic bad);
      int s;
      logic [7:0] c;
      s = (int'(hi) + int'(hf) + int'(ti) + int'(tf)) % 256;
      if (bad) s = s ^ 1;
      c = s[7:0];
      return {hi, hf, ti, tf, c};
   endfunction

   function automatic bit near(input int n, input int us);
      return (n >= us*CPU - 1) && (n <= us*CPU + 1);
   endfunction

   // Counts cycles the drive stays at lvl; -1 if the budget runs out.
   task automatic meas(input logic lvl, input int budget, output int n);
      n = 0;
      while (dif.dht_drive_low === lvl) begin
         if (n >= budget) begin n = -1; return; end
         @(negedge clk);
         n++;
      end
   endtask

   task automatic run_frame(input logic [7:0] hi, hf, ti, tf, input logic bad,
                            input int host_us, input logic [7:0] ti_late, input int stop_bit,
                            output logic [39:0] bits, output int terr, output logic busy_mid);
      int n;
      dif.hum_int = hi; dif.hum_float = hf; dif.temp_int = ti; dif.temp_float = tf;
      dif.bad_checksum = bad;
      bits = '0; terr = 0; busy_mid = 1'b0;
      @(negedge clk);
      dif.dht_in = 1'b0;
      repeat (host_us*CPU) @(negedge clk);
      dif.dht_in = 1'b1;
      meas(1'b0, (RD+10)*CPU, n);
      if (n < RD*CPU+2 || n > RD*CPU+4) terr++;
      if (n < 0) return;
      busy_mid = dif.busy;
      dif.temp_int = ti_late;
      meas(1'b1, 100*CPU, n); if (!near(n, 80)) terr++; if (n < 0) return;
      meas(1'b0, 100*CPU, n); if (!near(n, 80)) terr++; if (n < 0) return;
      for (int i = 0; i < 40; i++) begin
         if (i == stop_bit) return;
         meas(1'b1, 100*CPU, n); if (!near(n, 50)) terr++; if (n < 0) return;
         meas(1'b0, 100*CPU, n);
         if (n < 0) begin terr++; return; end
         bits = {bits[38:0], (n > 48*CPU)};
         if (!near(n, 26) && !near(n, 70)) terr++;
      end
      meas(1'b1, 100*CPU, n); if (!near(n, 50)) terr++;
   endtask

   task automatic full_frame(input string tag, input logic [7:0] hi, hf, ti, tf, input logic bad,
                             input int host_us, input logic [7:0] ti_late);
      logic [39:0] bits;
      int          terr;
      logic        bm;
      int          d0;
      d0 = done_cnt;
      run_frame(hi, hf, ti, tf, bad, host_us, ti_late, -1, bits, terr, bm);
      repeat (4) @(negedge clk);
      exp_fc++;
      chk({tag, "_bits"},   64'(bits), 64'(model(hi, hf, ti, tf, bad)));
      chk({tag, "_timing"}, 64'(terr), 64'd0);
      chk({tag, "_busy"},   64'(bm), 64'd1);
      chk({tag, "_done"},   64'(done_cnt), 64'(d0 + 1));
      chk({tag, "_fcount"}, 64'(dif.frame_count), 64'(exp_fc[15:0]));
      chk({tag, "_idle"},   64'({dif.busy, dif.dht_drive_low}), 64'd0);
   endtask

   initial begin
      logic [39:0] bits;
      int          terr, d0, viol;
      logic        bm;
      logic [7:0]  r0, r1, r2, r3;

      dif.dht_in = 1'b1; dif.hum_int = 8'd0; dif.hum_float = 8'd0;
      dif.temp_int = 8'd0; dif.temp_float = 8'd0; dif.bad_checksum = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_drive", 64'(dif.dht_drive_low), 64'd0);
      chk("rst_busy",  64'(dif.busy), 64'd0);
      chk("rst_done",  64'(dif.done), 64'd0);
      chk("rst_fc",    64'(dif.frame_count), 64'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Reset during bit 20 of a random frame.
      r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
      d0 = done_cnt;
      run_frame(r0, r1, r2, r3, 1'b0, 150, r2, 20, bits, terr, bm);
      chk("mid_reach", 64'(terr), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_drive", 64'(dif.dht_drive_low), 64'd0);
      chk("mid_busy",  64'(dif.busy), 64'd0);
      rst = 1'b0;
      repeat (200*CPU) @(negedge clk);
      chk("mid_nodone", 64'(done_cnt), 64'(d0));
      chk("mid_fc",     64'(dif.frame_count), 64'(exp_fc[15:0]));

      // Nominal frame; temp_int changes during presence low and must not leak.
      full_frame("nominal", 8'd55, 8'd0, 8'd24, 8'd0, 1'b0, 180, 8'd99);

      // Runt start then a random frame.
      @(negedge clk);
      dif.dht_in = 1'b0;
      repeat (50*CPU) @(negedge clk);
      dif.dht_in = 1'b1;
      viol = 0;
      for (int i = 0; i < 200*CPU; i++) begin
         @(negedge clk);
         if (dif.busy !== 1'b0 || dif.dht_drive_low !== 1'b0) viol++;
      end
      chk("runt_quiet", 64'(viol), 64'd0);
      chk("runt_fc",    64'(dif.frame_count), 64'(exp_fc[15:0]));
      r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
      full_frame("random", r0, r1, r2, r3, 1'($urandom), 150, r2);

      // Checksum wrap, then injected error with a host low of exactly MIN.
      full_frame("cks_ff",  8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 150, 8'hFF);
      full_frame("cks_bad", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, MIN, 8'hFF);

      // Alternating bit widths.
      full_frame("alt_aa", 8'hAA, 8'h00, 8'h00, 8'h00, 1'b0, 150, 8'h00);

      chk("done_with_busy_fall", 64'(done_bad), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
